// File: rtl/div_period_meter_if.sv
// Signal bundle for div_period_meter: measured input and result outputs.
// master drives pi_sig and observes results; slave is the meter itself.
interface div_period_meter_if #(
   parameter int CNT_W = 8
);
   logic             pi_sig;
   logic [CNT_W-1:0] po_period;
   logic [CNT_W-1:0] po_high;
   logic             po_valid;
   logic             po_lock;
   logic             po_err;

   modport master (
      output pi_sig,
      input  po_period, po_high, po_valid, po_lock, po_err
   );

   modport slave (
      input  pi_sig,
      output po_period, po_high, po_valid, po_lock, po_err
   );
endinterface

// File: rtl/div_period_meter.sv
// Period / high-time meter with lock and timeout for a divided signal.
// DIV_PERIOD_METER_SYNC_EN adds a 2-flop input synchronizer.
module div_period_meter #(
   parameter int CNT_W  = 8,
   parameter int LOCK_N = 4
) (
   input logic              clk,
   input logic              rst,
   div_period_meter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_MEAS,
      S_TOUT
   } state_t;

   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [3:0]       C_MMAX = 4'(LOCK_N - 1);

   state_t           r_state;
   state_t           w_next;
   logic             w_sig;
   logic             w_rise;
   logic             w_tout;
   logic             r_sig_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic             r_valid;
   logic             r_lock;
   logic             r_err;
   logic [3:0]       r_match;
   logic [3:0]       w_match;

`ifdef DIV_PERIOD_METER_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], bus.pi_sig};
   end

   assign w_sig = r_sync[1];
`else
   assign w_sig = bus.pi_sig;
`endif

   assign w_rise = w_sig & ~r_sig_d;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_tout = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_rise) w_next = S_MEAS;
         S_MEAS: begin
            w_tout = ~w_rise && (r_cnt == C_LAST);
            if (w_tout) w_next = S_TOUT;
         end
         S_TOUT: if (w_rise) w_next = S_MEAS;
         default: w_next = S_IDLE;
      endcase
   end

   // match counter saturates so a long locked run keeps lock asserted
   always_comb begin
      w_match = 4'd0;
      if (r_cnt == r_period)
         w_match = (r_match == C_MMAX) ? r_match : r_match + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sig_d  <= 1'b1;
         r_cnt    <= '0;
         r_hcnt   <= '0;
         r_period <= '0;
         r_high   <= '0;
         r_valid  <= 1'b0;
         r_lock   <= 1'b0;
         r_err    <= 1'b0;
         r_match  <= 4'd0;
      end else begin
         r_sig_d <= w_sig;
         r_valid <= 1'b0;
         if (r_state == S_MEAS) begin
            if (w_rise) begin
               r_period <= r_cnt;
               r_high   <= r_hcnt;
               r_valid  <= 1'b1;
               r_match  <= w_match;
               r_lock   <= (w_match == C_MMAX);
               r_cnt    <= C_ONE;
               r_hcnt   <= C_ONE;
            end else if (w_tout) begin
               r_err   <= 1'b1;
               r_lock  <= 1'b0;
               r_match <= 4'd0;
               r_cnt   <= r_cnt + C_ONE;
            end else begin
               r_cnt  <= r_cnt + C_ONE;
               r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, w_sig};
            end
         end else if (w_rise) begin
            r_cnt  <= C_ONE;
            r_hcnt <= C_ONE;
         end
      end
   end

   assign bus.po_period = r_period;
   assign bus.po_high   = r_high;
   assign bus.po_valid  = r_valid;
   assign bus.po_lock   = r_lock;
   assign bus.po_err    = r_err;
endmodule

// File: tb/tb_div_period_meter.sv
// Bench for div_period_meter: segment table, corner sequences and
// random stimulus against an edge-list reference model.
module tb_div_period_meter;
   localparam int W  = 8;
   localparam int LN = 4;
`ifdef DIV_PERIOD_METER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      int hi;
      int lo;
      int reps;
      int nval;
      int per;
      int hgh;
      int lck;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errs   = 0;
   int   checks = 0;
   int   nval   = 0;

   bit samp[$];
   bit eff[$];
   int phase;
   int ref_t;
   int run;
   int e_period, e_high, e_valid, e_lock, e_err;

   div_period_meter_if #(.CNT_W(W)) bus();

   div_period_meter #(.CNT_W(W), .LOCK_N(LN)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs < 40)
            $display("FAIL %s: got %0d want %0d (t=%0t)",
                     nm, act, exp, $time);
      end
   endtask

   // Reference: a period is the edge distance between successive seen
   // rises; high time is the number of high samples in that window.
   task automatic model(input bit v, input bit r);
      int n;
      bit ev, pv, rise;
      int p, h;
      e_valid = 0;
      if (r) begin
         samp.push_back(1'b1);
         eff.push_back(1'b1);
         phase = 0; run = 0;
         e_period = 0; e_high = 0;
         e_lock = 0; e_err = 0;
         return;
      end
      samp.push_back(v);
      n  = samp.size() - 1;
      ev = (n >= LAT) ? samp[n-LAT] : 1'b1;
      pv = (n >= 1) ? eff[n-1] : 1'b1;
      eff.push_back(ev);
      rise = ev && !pv;
      if (phase == 1) begin
         if (rise) begin
            p = n - ref_t;
            h = 0;
            for (int k = ref_t; k < n; k++) h += eff[k];
            run = (p == e_period) ? run + 1 : 1;
            e_period = p; e_high = h; e_valid = 1;
            e_lock = (run >= LN);
            ref_t = n;
         end else if (n - ref_t == (1 << W) - 2) begin
            phase = 2; e_err = 1; e_lock = 0; run = 1;
         end
      end else if (rise) begin
         phase = 1; ref_t = n;
      end
   endtask

   task automatic step(input bit v, input bit r);
      bus.pi_sig = v;
      rst = r;
      @(posedge clk);
      model(v, r);
      @(negedge clk);
      cmp("cyc_period", bus.po_period, e_period);
      cmp("cyc_high",   bus.po_high,   e_high);
      cmp("cyc_valid",  bus.po_valid,  e_valid);
      cmp("cyc_lock",   bus.po_lock,   e_lock);
      cmp("cyc_err",    bus.po_err,    e_err);
      if (bus.po_valid === 1'b1) nval++;
   endtask

   task automatic pat(input int hi, input int lo, input int reps);
      for (int i = 0; i < reps; i++) begin
         for (int j = 0; j < hi; j++) step(1'b1, 1'b0);
         for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
      end
   endtask

   task automatic do_rst();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
   endtask

   initial begin
      vec_t tbl[5];
      tbl[0] = '{2, 2, 5, 4, 4, 2, 1};
      tbl[1] = '{3, 3, 1, 1, 4, 2, 1};
      tbl[2] = '{3, 3, 4, 4, 6, 3, 1};
      tbl[3] = '{1, 3, 3, 3, 4, 1, 0};
      tbl[4] = '{1, 2, 3, 3, 3, 1, 0};

      bus.pi_sig = 1'b0;
      rst = 1'b1;
      do_rst();
      cmp("rst_period", bus.po_period, 0);
      cmp("rst_high",   bus.po_high,   0);
      cmp("rst_valid",  bus.po_valid,  0);
      cmp("rst_lock",   bus.po_lock,   0);
      cmp("rst_err",    bus.po_err,    0);
      step(1'b0, 1'b0);

      for (int t = 0; t < 5; t++) begin
         nval = 0;
         pat(tbl[t].hi, tbl[t].lo, tbl[t].reps);
         cmp($sformatf("seg%0d_nval", t), nval, tbl[t].nval);
         cmp($sformatf("seg%0d_per", t), bus.po_period, tbl[t].per);
         cmp($sformatf("seg%0d_high", t), bus.po_high, tbl[t].hgh);
         cmp($sformatf("seg%0d_lock", t), bus.po_lock, tbl[t].lck);
      end

      // timeout after a rise followed by a long low
      step(1'b1, 1'b0);
      for (int i = 0; i < 253 + LAT; i++) step(1'b0, 1'b0);
      cmp("tout_err_before", bus.po_err, 0);
      step(1'b0, 1'b0);
      cmp("tout_err", bus.po_err, 1);
      cmp("tout_lock", bus.po_lock, 0);
      cmp("tout_period_kept", bus.po_period, 3);
      nval = 0;
      pat(2, 2, 1);
      step(1'b1, 1'b0);
      for (int i = 0; i < 2 + LAT; i++) step(1'b0, 1'b0);
      cmp("tout_recover_nval", nval, 1);
      cmp("tout_recover_per", bus.po_period, 4);
      cmp("tout_err_sticky", bus.po_err, 1);

      // reset in the middle of a period
      step(1'b1, 1'b0);
      do_rst();
      cmp("mid_rst_period", bus.po_period, 0);
      cmp("mid_rst_err", bus.po_err, 0);
      cmp("mid_rst_lock", bus.po_lock, 0);
      step(1'b0, 1'b0);
      nval = 0;
      pat(2, 2, 3);
      for (int i = 0; i < LAT; i++) step(1'b0, 1'b0);
      cmp("post_rst_nval", nval, 2);
      cmp("post_rst_per", bus.po_period, 4);

      // stuck high after a rise also times out
      for (int i = 0; i < 255 + LAT; i++) step(1'b1, 1'b0);
      cmp("stuck_hi_err", bus.po_err, 1);
      cmp("stuck_hi_per", bus.po_period, 4);

      // longest measurable period just avoids the timeout
      do_rst();
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 253; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < LAT; i++) step(1'b1, 1'b0);
      cmp("max_per", bus.po_period, 254);
      cmp("max_high", bus.po_high, 1);
      cmp("max_err", bus.po_err, 0);
      step(1'b0, 1'b0);

      for (int i = 0; i < 250; i++) begin
         int hi, lo;
         hi = $urandom_range(1, 8);
         lo = ($urandom_range(0, 29) == 0) ?
              $urandom_range(250, 256) : $urandom_range(1, 8);
         if ($urandom_range(0, 49) == 0) begin
            do_rst();
            step(1'b0, 1'b0);
         end
         pat(hi, lo, ($urandom_range(0, 3) == 0) ? 5 : 1);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
